// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the picorv32 wait-state memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int STALL_W = 8;

  // Wait states requested by the bench, limited to what the responder allows.
  function automatic int unsigned clamp_wait(input int unsigned requested,
                                             input int unsigned max_wait);
    return (requested > max_wait) ? max_wait : requested;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Word RAM with per-byte write enables and an asynchronous read port; contents are never reset.
module mem_resp_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wait_responder.sv
// picorv32 native-bus memory responder with programmable wait states,
// handshake policing and a saturating stall counter.
module mem_wait_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int MAX_WAIT  = 7,
  parameter int WAIT_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid,
  input  logic               mem_instr,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  input  logic [WAIT_W-1:0]  wait_cycles,
  output logic               protocol_err,
  output logic               addr_err,
  output logic [STALL_W-1:0] stall_count
);

  state_t             state, state_next;
  logic [WAIT_W-1:0]  wcnt, wcnt_next, wait_clamped;
  logic               instr_q, bad_q;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         wstrb_q;
  logic               accept, abort, mismatch, bad_now;
  logic [3:0]         ram_we;
  logic [31:0]        ram_rdata;

  assign wait_clamped = WAIT_W'(clamp_wait(32'(wait_cycles), 32'(MAX_WAIT)));
  assign bad_now      = (mem_addr[1:0] != 2'b00) || (mem_addr[31:ADDR_BITS+2] != '0);

  // The request must stay stable from acceptance until the response edge.
  assign mismatch = (state != IDLE) && mem_valid &&
                    ((mem_instr != instr_q) || (mem_addr != addr_q) ||
                     (mem_wdata != wdata_q) || (mem_wstrb != wstrb_q));

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    accept     = 1'b0;
    abort      = 1'b0;
    ram_we     = 4'b0000;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          accept     = 1'b1;
          wcnt_next  = wait_clamped;
          state_next = (wait_clamped != '0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          wcnt_next = wcnt - WAIT_W'(1);
          if (wcnt == WAIT_W'(1)) state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
        if (!mem_valid) abort = 1'b1;
        else if (!bad_q) ram_we = wstrb_q;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      mem_ready    <= 1'b0;
      protocol_err <= 1'b0;
      addr_err     <= 1'b0;
      stall_count  <= '0;
    end else begin
      state     <= state_next;
      wcnt      <= wcnt_next;
      mem_ready <= (state_next == RESP);
      if (abort || mismatch) protocol_err <= 1'b1;
      if (accept && bad_now) addr_err <= 1'b1;
      if (mem_valid && !mem_ready && (stall_count != '1))
        stall_count <= stall_count + STALL_W'(1);
    end
  end

  // Request capture; these only matter while a transaction is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bad_q   <= 1'b0;
    end else if (accept) begin
      instr_q <= mem_instr;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      bad_q   <= bad_now;
    end
  end

  mem_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[ADDR_BITS+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign mem_rdata = (state == RESP && wstrb_q == 4'b0000 && !bad_q) ? ram_rdata : 32'h0;

endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Memory-side responder for the picorv32 native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Sits directly downstream of the core in bounded-model-check and simulation benches. Returns read data from a small byte-enabled word RAM and applies writes.
- Inserts a per-transaction programmable number of wait states.
- Polices the request handshake and counts stall cycles, so the bench can constrain or check them.

Parameters:
- ADDR_BITS, 10, word-address width; RAM holds 2**ADDR_BITS 32-bit words.
- MAX_WAIT, 7, upper clamp on wait states per transaction.
- WAIT_W, 3, width of the wait_cycles input; must satisfy 2**WAIT_W-1 >= MAX_WAIT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  core request valid.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write strobes; 0 means read.
- mem_ready  output  1  registered response strobe, one cycle.
- mem_rdata  output  32  read data, valid when mem_ready=1.
- wait_cycles  input  WAIT_W  wait states for the next accepted request.
- protocol_err  output  1  sticky handshake violation.
- addr_err  output  1  sticky out-of-range or misaligned access.
- stall_count  output  8  saturating count of cycles with mem_valid=1 and mem_ready=0.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state=IDLE.
  - mem_ready=0, mem_rdata=0, protocol_err=0, addr_err=0, stall_count=0.
  - RAM contents are not reset.
- State IDLE:
  - On an edge with mem_valid=1, latch mem_instr/addr/wdata/wstrb.
  - Load wcnt = min(wait_cycles, MAX_WAIT).
  - Go to WAIT if wcnt>0, else RESP.
- State WAIT:
  - Decrement wcnt each edge.
  - Go to RESP on the edge where wcnt reaches 0 after decrementing.
- State RESP (lasts exactly one cycle):
  - mem_ready=1.
  - mem_rdata = RAM[latched word index] for reads; 0 for writes and for addr_err accesses.
  - Write: at the edge ending RESP, bytes with wstrb[i]=1 are written.
  - Next state is IDLE.
- Latency: mem_ready is high in cycle N+1 after the cycle in which mem_valid is first sampled high, where N is the clamped wait_cycles.
- Read data is the RAM value at the acceptance edge plus any earlier writes. There is no read-during-write hazard because only one transaction is outstanding.
- Back-to-back requests:
  - mem_valid=1 in the cycle after RESP is a new request, accepted from IDLE.
  - Minimum spacing is one idle cycle (core behaviour).
- Handshake checks while in WAIT or RESP:
  - If mem_valid=0, set protocol_err. The transaction is aborted: go to IDLE, no write, no mem_ready.
  - If any of mem_instr, mem_addr, mem_wdata or mem_wstrb differs from the latched value, set protocol_err. The transaction continues with the latched values.
- Address checks, evaluated at acceptance:
  - Set addr_err if mem_addr[1:0]!=0, or if mem_addr[31:ADDR_BITS+2]!=0.
  - Such a transaction still completes with normal latency: read data 0, write suppressed.
- stall_count:
  - Increments on every edge with mem_valid=1 and mem_ready=0, in any state.
  - Saturates at 255.
- Reset asserted mid-transaction: immediate return to IDLE, mem_ready=0, no write performed.
- protocol_err and addr_err clear only on reset.

Decomposition:
- Shared package mem_resp_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - STALL_W=8;
  - helper function clamp_wait.
- One sub-module, mem_resp_ram: single-port 2**ADDR_BITS x 32 RAM with 4 byte enables and a combinational read address. It has no reset.
- The FSM, checks and counters live in the top module.

Test Plan:
- Zero-wait read:
  - Stimulus: write 0xDEADBEEF to 0x10, then read 0x10 with wait_cycles=0.
  - Required: mem_ready high in the cycle after acceptance; mem_rdata=0xDEADBEEF; stall_count increments by 1 per transaction.
- Max-wait clamp:
  - Stimulus: wait_cycles=7 with MAX_WAIT=3, read request.
  - Required: mem_ready in cycle 4 after acceptance; stall_count +4.
- Byte-strobe write:
  - Stimulus: word 0x11223344, then write 0xAABBCCDD with wstrb=4'b0101.
  - Required: readback 0x11BB33DD.
- Aborted request:
  - Stimulus: drop mem_valid in WAIT while a write with wstrb=4'hF is pending.
  - Required: protocol_err=1, no mem_ready, RAM word unchanged.
- Address error:
  - Stimulus: read 0x00001002, then read 0x00010000 (ADDR_BITS=10).
  - Required: both complete with mem_rdata=0; addr_err=1 sticky.
- Reset mid-WAIT:
  - Stimulus: assert reset during a pending write.
  - Required: all outputs 0 immediately; a later read of that word shows the old value.
